// File: rtl/mc_processor.sv
// mc_processor: parametrised multicycle integer processor (MIPS-format subset).
//
// Each instruction walks FETCH -> DECODE -> READ -> EXEC -> WB. The core then
// returns to FETCH, or goes to HALT once the program-length or retire-count
// bound is reached. HALT is left only through reset.
//
// Optional feature macro: MCPROC_BRANCH_EN
//   defined   -> beq (opcode 4) and bne (opcode 5) are executed.
//   undefined -> opcodes 4 and 5 are invalid and the next PC is always pc+1.
//
// Ports:
//   clk           clock; all state changes on its rising edge
//   rst_n         synchronous active-low reset
//   pc            address of the instruction being fetched/executed
//   instr_req     high while in FETCH
//   instr_valid   instruction word valid this cycle
//   instruction   32-bit word, captured when instr_req && instr_valid
//   retired       instructions retired, including invalid ones (saturates at 255)
//   err           sticky flag, set by any invalid instruction
//   done          high in HALT
//   final_result  reg[OUT_REG] while done, otherwise 0
module mc_processor #(
    parameter int DATA_W     = 8,
    parameter int NREGS      = 32,
    parameter int PC_W       = 4,
    parameter int PROG_LEN   = 8,
    parameter int MAX_RETIRE = 255,
    parameter int OUT_REG    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   pc,
    output logic              instr_req,
    input  logic              instr_valid,
    input  logic [31:0]       instruction,
    output logic [7:0]        retired,
    output logic              err,
    output logic              done,
    output logic [DATA_W-1:0] final_result
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
`ifdef MCPROC_BRANCH_EN
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
`endif

    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUBU = 6'd35;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    state_t            state;
    logic [31:0]       ir;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] regs [NREGS];

    // Values captured at the end of EXEC and consumed by WB.
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_dest;
    logic              wb_valid;
`ifdef MCPROC_BRANCH_EN
    logic              wb_taken;
    logic              x_taken;
`endif

    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_z;
    logic [DATA_W-1:0] x_data;
    logic [4:0]        x_dest;
    logic              x_valid;

    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   pc_next;
    logic [7:0]        retired_next;
    logic              halt_next;

    // Register indices are 5-bit fields; anything at or above NREGS is invalid.
    function automatic logic idx_ok(input logic [4:0] idx);
        return int'(idx) < NREGS;
    endfunction

    // EXEC datapath: result, destination and validity from decoded fields.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a variable unassigned (which would infer a latch).
        imm_s   = DATA_W'($signed(imm));   // sign-extend or truncate
        imm_z   = DATA_W'(imm);            // zero-extend or truncate
        x_data  = '0;
        x_dest  = '0;
        x_valid = 1'b0;
`ifdef MCPROC_BRANCH_EN
        x_taken = 1'b0;
`endif
        case (opcode)
            OP_RTYPE: begin
                x_dest  = rd;
                x_valid = idx_ok(rs) && idx_ok(rt) && idx_ok(rd);
                case (func)
                    FN_ADDU: x_data = src1 + src2;
                    FN_SUBU: x_data = src1 - src2;
                    FN_AND:  x_data = src1 & src2;
                    FN_OR:   x_data = src1 | src2;
                    FN_SLT:  x_data = DATA_W'($signed(src1) < $signed(src2));
                    default: x_valid = 1'b0;
                endcase
            end
            OP_ADDIU, OP_ANDI, OP_ORI: begin
                x_dest  = rt;
                x_valid = idx_ok(rs) && idx_ok(rt);
                case (opcode)
                    OP_ADDIU: x_data = src1 + imm_s;
                    OP_ANDI:  x_data = src1 & imm_z;
                    default:  x_data = src1 | imm_z;
                endcase
            end
`ifdef MCPROC_BRANCH_EN
            OP_BEQ, OP_BNE: begin
                // Destination stays r0, so a branch never writes a register.
                x_valid = idx_ok(rs) && idx_ok(rt);
                x_taken = x_valid && ((src1 == src2) == (opcode == OP_BEQ));
            end
`endif
            default: ;
        endcase
    end

    // Next PC, retire count and halt decision, all evaluated during WB.
    always_comb begin
        pc_inc  = pc + PC_W'(1);
        pc_next = pc_inc;
`ifdef MCPROC_BRANCH_EN
        if (wb_taken) pc_next = pc_inc + imm[PC_W-1:0];
`endif
        retired_next = (retired == 8'hFF) ? retired : retired + 8'd1;
        halt_next    = (int'(pc_next) >= PROG_LEN) || (int'(retired_next) == MAX_RETIRE);
    end

    // NOTE: the register file sits in the reset branch because the architecture
    // requires every register to read zero after reset; the staging registers
    // (ir, fields, src, wb_*) are not reset since each is written before use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= '0;
            retired   <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            instr_req <= 1'b1;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every state element
            // updates from the values present before this edge.
            case (state)
                S_FETCH: begin
                    if (instr_valid) begin
                        ir        <= instruction;
                        instr_req <= 1'b0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opcode <= ir[31:26];
                    rs     <= ir[25:21];
                    rt     <= ir[20:16];
                    rd     <= ir[15:11];
                    func   <= ir[5:0];
                    imm    <= ir[15:0];
                    state  <= S_READ;
                end
                S_READ: begin
                    src1  <= idx_ok(rs) ? regs[rs] : '0;
                    src2  <= idx_ok(rt) ? regs[rt] : '0;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    wb_data  <= x_data;
                    wb_dest  <= x_dest;
                    wb_valid <= x_valid;
`ifdef MCPROC_BRANCH_EN
                    wb_taken <= x_taken;
`endif
                    state    <= S_WB;
                end
                S_WB: begin
                    if (wb_valid && wb_dest != 5'd0) regs[wb_dest] <= wb_data;
                    if (!wb_valid) err <= 1'b1;
                    retired <= retired_next;
                    pc      <= pc_next;
                    if (halt_next) begin
                        state <= S_HALT;
                        done  <= 1'b1;
                    end else begin
                        state     <= S_FETCH;
                        instr_req <= 1'b1;
                    end
                end
                S_HALT: ;
                default: begin
                    state     <= S_FETCH;
                    instr_req <= 1'b1;
                end
            endcase
        end
    end

    // No register writes happen in HALT, so this tracks reg[OUT_REG] directly.
    assign final_result = done ? regs[OUT_REG] : '0;

endmodule

// File: tb/tb_mc_processor.sv
module tb_mc_processor;
    localparam int DW   = 8;
    localparam int PCW  = 4;
    localparam int PLEN = 8;
    localparam int MAXR = 255;
    localparam int OREG = 2;
    localparam int MASK = (1 << DW) - 1;
`ifdef MCPROC_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [PCW-1:0] pc;
    logic           instr_req;
    logic           instr_valid = 1'b0;
    logic [31:0]    instruction = '0;
    logic [7:0]     retired;
    logic           err;
    logic           done;
    logic [DW-1:0]  final_result;

    mc_processor #(
        .DATA_W(DW), .NREGS(32), .PC_W(PCW), .PROG_LEN(PLEN),
        .MAX_RETIRE(MAXR), .OUT_REG(OREG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr_req(instr_req),
        .instr_valid(instr_valid), .instruction(instruction),
        .retired(retired), .err(err), .done(done), .final_result(final_result)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction store contents and per-fetch stall lengths.
    logic [31:0] prog [16];
    int          stalls [16];

    // Reference model results.
    int m_regs [32];
    int m_err, m_ret, m_pc, m_cyc, m_first;

    // Observations from the last run.
    int o_cyc, o_first;
    bit o_done;

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Word shown while the core is not fetching; would clobber r2 if executed.
    function automatic logic [31:0] junk();
        return enc_i(9, 0, 2, {8'($urandom), 8'h5A});
    endfunction

    function automatic int sgn(int x);
        return (x > MASK / 2) ? x - (MASK + 1) : x;
    endfunction

    task automatic load_nops();
        for (int i = 0; i < 16; i++) begin
            prog[i]   = enc_r(0, 0, 0, 37);   // or r0,r0,r0
            stalls[i] = 0;
        end
    endtask

    // Instruction-level interpreter of the program in prog[].
    task automatic model_run();
        int p, fi, op, rs, rt, rd, fn, imm, simm, a, b, val, dst, npc;
        bit ok;
        logic [31:0] w;
        foreach (m_regs[i]) m_regs[i] = 0;
        p = 0; fi = 0; m_err = 0; m_ret = 0; m_cyc = 0; m_first = 0;
        forever begin
            w = prog[p];
            m_cyc += 5 + stalls[fi % 16];
            if (fi == 0) m_first = m_cyc;
            fi++;
            op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
            rd = int'(w[15:11]); fn = int'(w[5:0]);   imm = int'(w[15:0]);
            simm = (imm >= 32768) ? imm - 65536 : imm;
            a = m_regs[rs]; b = m_regs[rt];
            ok = 1'b0; dst = 0; val = 0; npc = (p + 1) % 16;
            if (op == 0) begin
                ok = 1'b1; dst = rd;
                if      (fn == 33) val = (a + b) & MASK;
                else if (fn == 35) val = (a - b) & MASK;
                else if (fn == 36) val = a & b;
                else if (fn == 37) val = a | b;
                else if (fn == 42) val = (sgn(a) < sgn(b)) ? 1 : 0;
                else ok = 1'b0;
            end else if (op == 9) begin
                ok = 1'b1; dst = rt; val = (a + simm) & MASK;
            end else if (op == 12) begin
                ok = 1'b1; dst = rt; val = a & imm & MASK;
            end else if (op == 13) begin
                ok = 1'b1; dst = rt; val = (a | imm) & MASK;
            end else if ((op == 4 || op == 5) && BR_EN) begin
                ok = 1'b1;
                if ((op == 4) == (a == b)) npc = (p + 1 + imm) % 16;
            end
            if (!ok) m_err = 1;
            else if (dst != 0) m_regs[dst] = val;
            if (m_ret < 255) m_ret++;
            p = npc;
            if (npc >= PLEN || m_ret == MAXR) break;
        end
        m_pc = p;
    endtask

    // Hold reset for two edges; returns at a falling edge with rst_n still low.
    task automatic apply_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Releases reset (caller is at a falling edge) and acts as the instruction
    // store until done or the cycle bound expires.
    task automatic run_dut(input int bound);
        int fi, left;
        fi = 0; left = stalls[0]; o_first = -1; o_done = 1'b0; o_cyc = 0;
        rst_n = 1'b1;
        while (o_cyc < bound) begin
            if (instr_req && left > 0) begin
                instr_valid = 1'b0; instruction = junk(); left--;
            end else if (instr_req) begin
                instr_valid = 1'b1; instruction = prog[pc];
                fi++; left = stalls[fi % 16];
            end else begin
                instr_valid = 1'($urandom); instruction = junk();
            end
            @(posedge clk); o_cyc++;
            @(negedge clk);
            if (o_first < 0 && retired != 8'd0) o_first = o_cyc;
            if (done) begin o_done = 1'b1; break; end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (pc !== '0) begin n_bad++; $display("FAIL reset_pc: got %0h want 0", pc); end
        n_cmp++; if (retired !== 8'd0) begin n_bad++; $display("FAIL reset_retired: got %0d want 0", retired); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (final_result !== '0) begin n_bad++; $display("FAIL reset_final: got %0h want 0", final_result); end
        n_cmp++; if (instr_req !== 1'b1) begin n_bad++; $display("FAIL reset_req: got %b want 1", instr_req); end
    endtask

    task automatic test_addiu_chain();
        load_nops();
        prog[0] = enc_i(9, 0, 1, 5);
        prog[1] = enc_i(9, 1, 2, 3);
        apply_reset(); run_dut(1000);
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL chain_done: got %b want 1", o_done); end
        n_cmp++; if (final_result !== 8'd8) begin n_bad++; $display("FAIL chain_result: got %0h want 8", final_result); end
        n_cmp++; if (retired !== 8'd8) begin n_bad++; $display("FAIL chain_retired: got %0d want 8", retired); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL chain_err: got %b want 0", err); end
        n_cmp++; if (o_cyc != 40) begin n_bad++; $display("FAIL chain_cycles: got %0d want 40", o_cyc); end
        n_cmp++; if (o_first != 5) begin n_bad++; $display("FAIL chain_first_wb: got %0d want 5", o_first); end
        n_cmp++; if (pc !== 4'd8) begin n_bad++; $display("FAIL chain_pc: got %0d want 8", pc); end
    endtask

    task automatic test_subu_slt();
        load_nops();
        prog[0] = enc_i(9, 0, 1, 3);
        prog[1] = enc_i(9, 0, 3, 5);
        prog[2] = enc_r(1, 3, 2, 35);
        apply_reset(); run_dut(1000);
        n_cmp++; if (final_result !== 8'hFE) begin n_bad++; $display("FAIL subu_result: got %0h want fe", final_result); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL subu_err: got %b want 0", err); end
        prog[2] = enc_r(1, 3, 2, 42);
        apply_reset(); run_dut(1000);
        n_cmp++; if (final_result !== 8'd1) begin n_bad++; $display("FAIL slt_result: got %0h want 1", final_result); end
        prog[0] = enc_i(9, 0, 1, -3);   // -3 < 5 signed, 0xFD > 5 unsigned
        apply_reset(); run_dut(1000);
        n_cmp++; if (final_result !== 8'd1) begin n_bad++; $display("FAIL slt_signed: got %0h want 1", final_result); end
    endtask

    task automatic test_r0_and_invalid();
        load_nops();
        prog[0] = enc_i(9, 0, 0, 7);
        prog[1] = enc_r(0, 0, 2, 33);
        apply_reset(); run_dut(1000);
        n_cmp++; if (final_result !== 8'd0) begin n_bad++; $display("FAIL r0_result: got %0h want 0", final_result); end
        prog[0] = enc_i(9, 0, 2, 6);
        prog[1] = enc_r(2, 2, 2, 63);
        apply_reset(); run_dut(1000);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL invalid_err: got %b want 1", err); end
        n_cmp++; if (final_result !== 8'd6) begin n_bad++; $display("FAIL invalid_nowrite: got %0h want 6", final_result); end
        n_cmp++; if (retired !== 8'd8) begin n_bad++; $display("FAIL invalid_retired: got %0d want 8", retired); end
    endtask

    task automatic test_stall();
        load_nops();
        prog[0] = enc_i(9, 0, 1, 5);
        prog[1] = enc_i(9, 1, 2, 3);
        stalls[0] = 3;
        apply_reset(); run_dut(1000);
        n_cmp++; if (o_first != 8) begin n_bad++; $display("FAIL stall_first_wb: got %0d want 8", o_first); end
        n_cmp++; if (o_cyc != 43) begin n_bad++; $display("FAIL stall_cycles: got %0d want 43", o_cyc); end
        n_cmp++; if (final_result !== 8'd8) begin n_bad++; $display("FAIL stall_result: got %0h want 8", final_result); end
    endtask

    task automatic test_branch();
        int exp_res, exp_ret, exp_cyc;
        bit exp_err;
        load_nops();
        prog[0] = enc_i(4, 0, 0, 1);    // beq r0,r0,+1
        prog[1] = enc_i(9, 0, 3, 1);    // addiu r3,r0,1
        prog[2] = enc_i(9, 3, 2, 9);    // addiu r2,r3,9
        exp_res = BR_EN ? 9 : 10;
        exp_err = !BR_EN;
        exp_ret = BR_EN ? 7 : 8;
        exp_cyc = exp_ret * 5;
        apply_reset(); run_dut(1000);
        n_cmp++; if (final_result !== DW'(exp_res)) begin n_bad++; $display("FAIL branch_result: got %0d want %0d", final_result, exp_res); end
        n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL branch_err: got %b want %b", err, exp_err); end
        n_cmp++; if (retired !== 8'(exp_ret)) begin n_bad++; $display("FAIL branch_retired: got %0d want %0d", retired, exp_ret); end
        n_cmp++; if (o_cyc != exp_cyc) begin n_bad++; $display("FAIL branch_cycles: got %0d want %0d", o_cyc, exp_cyc); end
    endtask

    task automatic test_reset_mid_exec();
        load_nops();
        prog[0] = enc_i(9, 0, 2, 8'h33);
        apply_reset(); run_dut(1000);
        n_cmp++; if (final_result !== 8'h33) begin n_bad++; $display("FAIL pre_reset_result: got %0h want 33", final_result); end
        // One reset edge taken from HALT.
        rst_n = 1'b0; @(posedge clk); @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL halt_reset_done: got %b want 0", done); end
        n_cmp++; if (final_result !== '0) begin n_bad++; $display("FAIL halt_reset_final: got %0h want 0", final_result); end
        // Fetch addiu r2,r0,4, then drop reset for the edge that leaves EXEC.
        rst_n = 1'b1; instr_valid = 1'b1; instruction = enc_i(9, 0, 2, 4);
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0; instruction = junk();
        repeat (2) begin @(posedge clk); @(negedge clk); end
        n_cmp++; if (instr_req !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got req %b want 0", instr_req); end
        rst_n = 1'b0; @(posedge clk); @(negedge clk);
        n_cmp++; if (pc !== '0) begin n_bad++; $display("FAIL mid_reset_pc: got %0h want 0", pc); end
        n_cmp++; if (retired !== 8'd0) begin n_bad++; $display("FAIL mid_reset_retired: got %0d want 0", retired); end
        n_cmp++; if (instr_req !== 1'b1) begin n_bad++; $display("FAIL mid_reset_req: got %b want 1", instr_req); end
        // A program that never writes r2 must finish with r2 still zero.
        load_nops();
        run_dut(1000);
        n_cmp++; if (final_result !== 8'd0) begin n_bad++; $display("FAIL mid_reset_r2: got %0h want 0", final_result); end
        n_cmp++; if (o_cyc != 40) begin n_bad++; $display("FAIL mid_restart_cycles: got %0d want 40", o_cyc); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 16; k++) begin
                int sel, rs, rt, rd;
                sel = $urandom_range(0, 11);
                rs = $urandom_range(0, 3); rt = $urandom_range(0, 3); rd = $urandom_range(0, 3);
                case (sel)
                    0: prog[k] = enc_r(rs, rt, rd, 33);
                    1: prog[k] = enc_r(rs, rt, rd, 35);
                    2: prog[k] = enc_r(rs, rt, rd, 36);
                    3: prog[k] = enc_r(rs, rt, rd, 37);
                    4: prog[k] = enc_r(rs, rt, rd, 42);
                    5, 6: prog[k] = enc_i(9, rs, rt, $urandom);
                    7: prog[k] = enc_i(12, rs, rt, $urandom);
                    8: prog[k] = enc_i(13, rs, rt, $urandom);
                    9: prog[k] = enc_r(rs, rt, rd, $urandom_range(0, 63));
                    10: prog[k] = enc_i($urandom_range(4, 5), rs, rt, $urandom);
                    default: prog[k] = $urandom;
                endcase
                stalls[k] = $urandom_range(0, 2);
            end
            model_run();
            apply_reset(); run_dut(5000);
            n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_done: got %b want 1", t, o_done); end
            n_cmp++; if (final_result !== DW'(m_regs[OREG])) begin n_bad++; $display("FAIL rnd%0d_result: got %0h want %0h", t, final_result, m_regs[OREG]); end
            n_cmp++; if (retired !== 8'(m_ret)) begin n_bad++; $display("FAIL rnd%0d_retired: got %0d want %0d", t, retired, m_ret); end
            n_cmp++; if (err !== 1'(m_err)) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %0d", t, err, m_err); end
            n_cmp++; if (pc !== PCW'(m_pc)) begin n_bad++; $display("FAIL rnd%0d_pc: got %0d want %0d", t, pc, m_pc); end
            n_cmp++; if (o_cyc != m_cyc) begin n_bad++; $display("FAIL rnd%0d_cycles: got %0d want %0d", t, o_cyc, m_cyc); end
            n_cmp++; if (o_first != m_first) begin n_bad++; $display("FAIL rnd%0d_first_wb: got %0d want %0d", t, o_first, m_first); end
        end
    endtask

    initial begin
        test_reset();
        test_addiu_chain();
        test_subu_slt();
        test_r0_and_invalid();
        test_stall();
        test_branch();
        test_reset_mid_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
